// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Receives a program image over an 8N1 UART line and writes it, as 16-bit
//   little-endian words (first byte = low half), into the program BSRAM
//   through its ad/din/wre inputs. The CPU is held in reset while a load
//   session is active. The session ends once the line has been quiet for
//   IDLE_TIMEOUT_CLKS, so the CPU restarts from address 0 with the new image.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         asynchronous, active-low reset
//   uart_rx     serial input, idle high, 8N1, LSB first
//   mem_ad      BSRAM write address
//   mem_din     BSRAM write data
//   mem_wre     BSRAM write enable, one-clk pulse per word
//   cpu_hold    high while a load session is active
//   word_count  words written in the current or last session
//   frame_err   sticky bad-stop-bit flag, cleared when a new session starts
module uart_prog_loader #(
  parameter int CLK_HZ            = 27000000,
  parameter int BAUD              = 115200,
  parameter int ADDR_W            = 11,
  parameter int IDLE_TIMEOUT_CLKS = 2700000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [15:0]       mem_din,
  output logic              mem_wre,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   word_count,
  output logic              frame_err
);

  localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF   = DIV / 2;
  localparam int BAUD_W = $clog2(DIV + 1);
  localparam int TO_W   = $clog2(IDLE_TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_state_t;

  typedef enum logic [2:0] {
    L_IDLE, L_LOW, L_HIGH, L_WRITE, L_DONE
  } ld_state_t;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  rx_state_t         rx_state;
  logic              sync1, sync2, rx_prev;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              byte_valid;
  logic              stop_err;

  // NOTE: every register here is updated with non-blocking assignments so all
  // flops sample the values from before the edge, exactly like the hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Synchroniser resets to the idle line level so reset release is not
      // mistaken for a start bit.
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      sync1      <= uart_rx;
      sync2      <= sync1;
      rx_prev    <= sync2;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !sync2) begin
            rx_state <= RX_START;
            baud_cnt <= '0;
          end
        end
        RX_START: begin
          // Mid-start-bit check; a line already back high was only a glitch.
          if (baud_cnt == BAUD_W'(HALF - 1)) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            rx_state <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        RX_DATA: begin
          if (baud_cnt == BAUD_W'(DIV - 1)) begin
            baud_cnt <= '0;
            shreg    <= {sync2, shreg[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        RX_STOP: begin
          if (baud_cnt == BAUD_W'(DIV - 1)) begin
            baud_cnt <= '0;
            if (sync2) begin
              byte_valid <= 1'b1;
              rx_state   <= RX_IDLE;
            end else begin
              stop_err   <= 1'b1;
              rx_state   <= RX_WAIT;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        RX_WAIT: begin
          // A broken frame may leave the line low; resync only once it is idle.
          if (sync2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------------
  ld_state_t       ld_state;
  logic [7:0]      lo;
  logic [TO_W-1:0] to_cnt;
  logic            last_wr;
  logic            full;
  logic            timeout;

  // word_count doubles as the write address: both start at 0 and advance
  // together, and its top bit marks a full memory.
  assign full    = word_count[ADDR_W];
  assign timeout = (to_cnt == TO_W'(IDLE_TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state   <= L_IDLE;
      lo         <= '0;
      to_cnt     <= '0;
      last_wr    <= 1'b0;
      mem_ad     <= '0;
      mem_din    <= '0;
      mem_wre    <= 1'b0;
      cpu_hold   <= 1'b0;
      word_count <= '0;
      frame_err  <= 1'b0;
    end else begin
      mem_wre <= 1'b0;
      if (stop_err) frame_err <= 1'b1;

      // Quiet-line timer: only valid bytes restart it, framing errors do not.
      if (byte_valid || !(ld_state == L_LOW || ld_state == L_HIGH))
        to_cnt <= '0;
      else if (!timeout)
        to_cnt <= to_cnt + TO_W'(1);

      case (ld_state)
        L_IDLE: begin
          if (byte_valid) begin
            cpu_hold   <= 1'b1;
            mem_ad     <= '0;
            word_count <= '0;
            frame_err  <= 1'b0;
            lo         <= shreg;
            ld_state   <= L_HIGH;
          end
        end
        L_LOW: begin
          if (byte_valid) begin
            lo       <= shreg;
            ld_state <= L_HIGH;
          end else if (timeout) begin
            cpu_hold <= 1'b0;
            ld_state <= L_DONE;
          end
        end
        L_HIGH: begin
          if (byte_valid) begin
            if (full) begin
              ld_state <= L_LOW;
            end else begin
              mem_wre  <= 1'b1;
              mem_ad   <= word_count[ADDR_W-1:0];
              mem_din  <= {shreg, lo};
              last_wr  <= 1'b0;
              ld_state <= L_WRITE;
            end
          end else if (timeout) begin
            // Odd byte left over: flush it zero-extended as the final word.
            if (full) begin
              cpu_hold <= 1'b0;
              ld_state <= L_DONE;
            end else begin
              mem_wre  <= 1'b1;
              mem_ad   <= word_count[ADDR_W-1:0];
              mem_din  <= {8'h00, lo};
              last_wr  <= 1'b1;
              ld_state <= L_WRITE;
            end
          end
        end
        L_WRITE: begin
          word_count <= word_count + (ADDR_W + 1)'(1);
          if (last_wr) begin
            cpu_hold <= 1'b0;
            ld_state <= L_DONE;
          end else begin
            ld_state <= L_LOW;
          end
        end
        L_DONE:  ld_state <= L_IDLE;
        default: ld_state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream stage of the program BSRAM: receives a program image over a UART RX pin and writes it as 16-bit words into the single-port BSRAM via its ad/din/wre inputs.
- Holds the CPU in reset while loading. Releases it when the line goes idle, so the CPU restarts from address 0 with the new image.
- Top-level integration: BSRAM ad = cpu_hold ? mem_ad : cpu_pc; wre = mem_wre; din = mem_din; CPU reset = rst & ~cpu_hold.

Parameters:
- CLK_HZ, 27000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- ADDR_W, 11, BSRAM word-address width.
- IDLE_TIMEOUT_CLKS, 2700000, clk cycles without a valid byte that end a load session.

Ports:
- clk  in  1  system clock; all logic is on posedge.
- rst  in  1  reset; asynchronous, active-low.
- uart_rx  in  1  serial input, idle high, 8N1, LSB first.
- mem_ad  out  ADDR_W  BSRAM write address.
- mem_din  out  16  BSRAM write data.
- mem_wre  out  1  BSRAM write enable, one-clk pulse per word.
- cpu_hold  out  1  high while a load session is active.
- word_count  out  ADDR_W+1  words written in the current or last session.
- frame_err  out  1  sticky; set on a bad stop bit.

Behaviour:
- Reset values (rst low, asynchronous):
  - mem_ad, mem_din, mem_wre, cpu_hold, word_count, frame_err = 0.
  - Both synchroniser flops = 1.
  - FSMs in IDLE.
- Baud divisor: DIV = (CLK_HZ + BAUD/2) / BAUD, integer.
- RX path:
  - uart_rx passes through a 2-FF synchroniser.
  - A falling edge on the synchronised line in RX_IDLE enters RX_START.
  - At DIV/2 clks the line is sampled. If high, it is a glitch: return to RX_IDLE, no error.
  - If low, go to RX_DATA and sample 8 bits at DIV intervals, LSB first.
  - RX_STOP samples the stop bit after another DIV.
    - Stop = 1: byte_valid pulses for one clk, then RX_IDLE.
    - Stop = 0: frame_err is set, the byte is discarded, and RX_WAIT holds until the line is high, then RX_IDLE.
- Loader FSM states: L_IDLE, L_LOW, L_HIGH, L_WRITE, L_DONE.
  - L_IDLE: on byte_valid, set cpu_hold=1, addr=0, word_count=0, frame_err=0; latch the byte as lo; go to L_HIGH.
  - L_LOW: on byte_valid, latch lo and go to L_HIGH.
  - L_HIGH: on byte_valid, latch hi and go to L_WRITE.
  - L_WRITE: for exactly one clk, mem_wre=1, mem_ad=addr, mem_din={hi,lo}. Then addr+1 and word_count+1; go to L_LOW. Total latency is 1 clk after the high-byte byte_valid.
  - Timeout counter: cleared on every byte_valid, counts in L_LOW/L_HIGH, and triggers at IDLE_TIMEOUT_CLKS.
    - In L_HIGH (odd byte pending): write {8'h00, lo} as a final L_WRITE, then L_DONE.
    - In L_LOW: go to L_DONE.
  - L_DONE: cpu_hold=0 for one clk, then L_IDLE. Gap between the last mem_wre and cpu_hold falling is ≥1 clk.
- Capacity:
  - When word_count = 2^ADDR_W, further words are discarded: no mem_wre, word_count saturates, addr does not wrap.
  - The session still ends on timeout.
- Frame errors inside a session do not change lo/hi byte pairing and do not clear the timeout counter.
- word_count and mem_ad hold their values after the session for inspection. mem_wre is 0 outside L_WRITE.
- If rst is asserted mid-session, all outputs reset immediately and cpu_hold drops. BSRAM keeps the partial image; no rollback.
- A new byte arriving while L_WRITE completes is accepted, since byte_valid cannot occur within DIV of the previous one.

Test Plan:
Bench settings: CLK_HZ=1000000, BAUD=100000 (DIV=10), IDLE_TIMEOUT_CLKS=500, ADDR_W=4.
- Send 0x34,0x12,0x78,0x56 then idle → mem_wre pulses at ad=0 din=0x1234 and ad=1 din=0x5678; cpu_hold rises at first byte_valid and falls ~500 clks after the last byte; word_count=2.
- Send 0xAA,0xBB,0xCC then idle → writes 0xBBAA@0, then 0x00CC@1 after timeout; word_count=2.
- Byte with stop bit=0 between 0x01 and 0x02 → frame_err=1, bad byte dropped, 0x0201 written @0.
- 3-clk low glitch on uart_rx → no byte_valid, frame_err stays 0, cpu_hold stays 0.
- 36 bytes (18 words) → 16 writes at ad 0..15, word_count=16, no write for words 17–18, cpu_hold falls after timeout.
- rst low mid-byte of the second word → all outputs 0 within the same cycle; after release, a fresh 2-byte load writes @0.
